// File: rtl/ctrl_pipe_decoder.sv
// Main control decoder for the 5-stage MIPS pipeline, with E/M/(W) control registers.
// Optional reserved-instruction detection is enabled by defining RI_DETECT_EN.
`timescale 1ns/1ps
module ctrl_pipe_decoder #(
  parameter int unsigned WB_STAGE        = 1,
  parameter int unsigned BUBBLE_ON_STALL = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] instrD,
  input  logic        stallE,
  input  logic        stallM,
  input  logic        stallW,
  input  logic        flushE,
  input  logic        flushM,
  input  logic        flushW,
  output logic        sign_extD,
  output logic [1:0]  reg_dstE,
  output logic        alu_imm_selE,
  output logic        reg_write_enE,
  output logic        reg_write_enM,
  output logic        reg_write_enW,
  output logic        mem_read_enM,
  output logic        mem_write_enM,
  output logic [1:0]  mem_sizeM,
  output logic        mem_signedM,
  output logic        mem_to_regM,
  output logic        mem_to_regW,
  output logic        hilo_writeM,
  output logic        ri_excM
);

  localparam bit BOS = (BUBBLE_ON_STALL != 0);

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LW    = 6'h23, OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25, OP_SB     = 6'h28, OP_SH    = 6'h29, OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL   = 6'h02, F_SRA  = 6'h03, F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06, F_SRAV  = 6'h07, F_JR   = 6'h08, F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI  = 6'h11, F_MFLO = 6'h12, F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV  = 6'h1A, F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD  = 6'h20, F_ADDU  = 6'h21, F_SUB  = 6'h22, F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24, F_OR    = 6'h25, F_XOR  = 6'h26, F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A, F_SLTU  = 6'h2B;

  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       mem_signed;
    logic       mem_to_reg;
    logic       hilo_write;
  } mctl_t;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic       alu_imm;
    mctl_t      m;
  } ectl_t;

  logic [5:0] op, funct;
  logic [4:0] rt;
  logic       known;
  ectl_t      dec, ctl_d, e_q;
  mctl_t      m_q;

  assign op    = instrD[31:26];
  assign funct = instrD[5:0];
  assign rt    = instrD[20:16];

  logic unused_bits;
  assign unused_bits = ^{instrD[25:21], instrD[15:6]};

  // Instruction decode; unrecognised encodings collapse to an all-zero bubble.
  always_comb begin
    dec       = '0;
    known     = 1'b1;
    sign_extD = 1'b1;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          F_JR: ;
          F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO: dec.m.hilo_write = 1'b1;
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_JALR, F_MFHI, F_MFLO,
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU:
            dec.m.reg_write = 1'b1;
          default: known = 1'b0;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ: ;
          RT_BLTZAL, RT_BGEZAL: begin
            dec.m.reg_write = 1'b1;
            dec.reg_dst     = 2'b10;
          end
          default: known = 1'b0;
        endcase
      end
      OP_J, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: ;
      OP_JAL: begin
        dec.m.reg_write = 1'b1;
        dec.reg_dst     = 2'b10;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        dec.m.reg_write = 1'b1;
        dec.reg_dst     = 2'b01;
        dec.alu_imm     = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        dec.m.reg_write = 1'b1;
        dec.reg_dst     = 2'b01;
        dec.alu_imm     = 1'b1;
        sign_extD       = 1'b0;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        dec.m.reg_write  = 1'b1;
        dec.reg_dst      = 2'b01;
        dec.alu_imm      = 1'b1;
        dec.m.mem_read   = 1'b1;
        dec.m.mem_to_reg = 1'b1;
        dec.m.mem_signed = (op == OP_LB) || (op == OP_LH);
        dec.m.mem_size   = (op == OP_LW) ? 2'b10 :
                           ((op == OP_LH) || (op == OP_LHU)) ? 2'b01 : 2'b00;
      end
      OP_SB, OP_SH, OP_SW: begin
        dec.alu_imm     = 1'b1;
        dec.m.mem_write = 1'b1;
        dec.m.mem_size  = (op == OP_SW) ? 2'b10 : (op == OP_SH) ? 2'b01 : 2'b00;
      end
      default: known = 1'b0;
    endcase
    ctl_d = known ? dec : '0;
  end

  // ID/EX: decode always feeds E, no upstream stall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      e_q <= '0;
    else if (flushE)  e_q <= '0;
    else if (!stallE) e_q <= ctl_d;
  end

  // EX/MEM: bubble when E is held but M advances (if configured).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      m_q <= '0;
    else if (flushM)  m_q <= '0;
    else if (!stallM) m_q <= (stallE && BOS) ? '0 : e_q.m;
  end

  assign reg_dstE      = e_q.reg_dst;
  assign alu_imm_selE  = e_q.alu_imm;
  assign reg_write_enE = e_q.m.reg_write;
  assign reg_write_enM = m_q.reg_write;
  assign mem_read_enM  = m_q.mem_read;
  assign mem_write_enM = m_q.mem_write;
  assign mem_sizeM     = m_q.mem_size;
  assign mem_signedM   = m_q.mem_signed;
  assign mem_to_regM   = m_q.mem_to_reg;
  assign hilo_writeM   = m_q.hilo_write;

  generate
    if (WB_STAGE != 0) begin : g_wb
      logic [1:0] w_q;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      w_q <= '0;
        else if (flushW)  w_q <= '0;
        else if (!stallW) w_q <= (stallM && BOS) ? 2'b00 : {m_q.reg_write, m_q.mem_to_reg};
      end
      assign reg_write_enW = w_q[1];
      assign mem_to_regW   = w_q[0];
    end else begin : g_no_wb
      logic unused_wb;
      assign unused_wb     = stallW ^ flushW;
      assign reg_write_enW = 1'b0;
      assign mem_to_regW   = 1'b0;
    end
  endgenerate

`ifdef RI_DETECT_EN
  logic ri_excD, ri_e, ri_m;
  assign ri_excD = ~known;

  // Reserved-instruction flag follows the same E/M update rules as the controls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      ri_e <= 1'b0;
    else if (flushE)  ri_e <= 1'b0;
    else if (!stallE) ri_e <= ri_excD;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      ri_m <= 1'b0;
    else if (flushM)  ri_m <= 1'b0;
    else if (!stallM) ri_m <= (stallE && BOS) ? 1'b0 : ri_e;
  end

  assign ri_excM = ri_m;
`else
  assign ri_excM = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// Bench for ctrl_pipe_decoder: two configurations (default, and WB_STAGE=0 / BUBBLE_ON_STALL=0)
// checked each cycle against a stage-slot reference model, plus directed literal checks.
`timescale 1ns/1ps
module tb_ctrl_pipe_decoder;

  typedef struct packed {
    logic rw; logic [1:0] dst; logic imm; logic mr; logic mw;
    logic [1:0] sz; logic sg; logic m2r; logic hl; logic ri;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] instrD = 32'h0800_0000;
  logic        stallE = 0, stallM = 0, stallW = 0, flushE = 0, flushM = 0, flushW = 0;

  logic       sx [2];
  logic [1:0] dstE [2];
  logic       immE [2], rwE [2], rwM [2], rwW [2], mrM [2], mwM [2];
  logic [1:0] szM [2];
  logic       sgM [2], m2rM [2], m2rW [2], hlM [2], riM [2];

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b1;

  localparam logic [31:0] FILL = 32'h0800_0000, LW = 32'h8C08_0000, LB = 32'h8008_0000;
  localparam logic [31:0] LHU = 32'h9408_0000, DIV = 32'h0000_001A, MFHI = 32'h0000_4010;
  localparam logic [31:0] BGEZAL = 32'h0411_0000, BGEZ = 32'h0401_0000, SW = 32'hAC08_0000;
  localparam logic [31:0] ADDI = 32'h2008_0005, INV = 32'hFC00_0000;

  ctrl_pipe_decoder #(.WB_STAGE(1), .BUBBLE_ON_STALL(1)) dut0 (
    .clk(clk), .resetn(resetn), .instrD(instrD),
    .stallE(stallE), .stallM(stallM), .stallW(stallW),
    .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .sign_extD(sx[0]), .reg_dstE(dstE[0]), .alu_imm_selE(immE[0]),
    .reg_write_enE(rwE[0]), .reg_write_enM(rwM[0]), .reg_write_enW(rwW[0]),
    .mem_read_enM(mrM[0]), .mem_write_enM(mwM[0]), .mem_sizeM(szM[0]),
    .mem_signedM(sgM[0]), .mem_to_regM(m2rM[0]), .mem_to_regW(m2rW[0]),
    .hilo_writeM(hlM[0]), .ri_excM(riM[0]));

  ctrl_pipe_decoder #(.WB_STAGE(0), .BUBBLE_ON_STALL(0)) dut1 (
    .clk(clk), .resetn(resetn), .instrD(instrD),
    .stallE(stallE), .stallM(stallM), .stallW(stallW),
    .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .sign_extD(sx[1]), .reg_dstE(dstE[1]), .alu_imm_selE(immE[1]),
    .reg_write_enE(rwE[1]), .reg_write_enM(rwM[1]), .reg_write_enW(rwW[1]),
    .mem_read_enM(mrM[1]), .mem_write_enM(mwM[1]), .mem_sizeM(szM[1]),
    .mem_signedM(sgM[1]), .mem_to_regM(m2rM[1]), .mem_to_regW(m2rW[1]),
    .hilo_writeM(hlM[1]), .ri_excM(riM[1]));

  always #5 clk = ~clk;

  // Reference decode, straight from the instruction-class rules.
  function automatic exp_t dec(input logic [31:0] i);
    exp_t e = '0;
    logic [5:0] op = i[31:26];
    logic [5:0] fn = i[5:0];
    logic [4:0] rt = i[20:16];
    if (op == 6'h00) begin
      if (fn == 6'h08) e.ri = 1'b0;
      else if (fn inside {6'h18, 6'h19, 6'h1A, 6'h1B, 6'h11, 6'h13}) e.hl = 1'b1;
      else if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h09, 6'h10, 6'h12,
                          [6'h20:6'h27], 6'h2A, 6'h2B}) e.rw = 1'b1;
      else e.ri = 1'b1;
    end else if (op == 6'h01) begin
      if (rt inside {5'h10, 5'h11}) begin e.rw = 1'b1; e.dst = 2'b10; end
      else if (!(rt inside {5'h00, 5'h01})) e.ri = 1'b1;
    end else if (op inside {6'h02, [6'h04:6'h07]}) begin
      e.ri = 1'b0;
    end else if (op == 6'h03) begin
      e.rw = 1'b1; e.dst = 2'b10;
    end else if (op inside {[6'h08:6'h0F]}) begin
      e.rw = 1'b1; e.dst = 2'b01; e.imm = 1'b1;
    end else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
      e.rw = 1'b1; e.dst = 2'b01; e.imm = 1'b1; e.mr = 1'b1; e.m2r = 1'b1;
      e.sz = (op == 6'h23) ? 2'd2 : (op inside {6'h21, 6'h25}) ? 2'd1 : 2'd0;
      e.sg = (op inside {6'h20, 6'h21});
    end else if (op inside {6'h28, 6'h29, 6'h2B}) begin
      e.imm = 1'b1; e.mw = 1'b1;
      e.sz = (op == 6'h2B) ? 2'd2 : (op == 6'h29) ? 2'd1 : 2'd0;
    end else begin
      e.ri = 1'b1;
    end
    if (e.ri) e = '{default: 1'b0, ri: 1'b1};
    return e;
  endfunction

  // Model: st[cfg][stage], stage 0=E 1=M 2=W; each slot obeys flush > stall > upstream-stall bubble > capture.
  exp_t st [2][3];
  bit   bos [2] = '{1'b1, 1'b0};
  bit   has_w [2] = '{1'b1, 1'b0};

  initial for (int d = 0; d < 2; d++) for (int s = 0; s < 3; s++) st[d][s] = '0;

  always @(posedge clk or negedge resetn) begin
    bit stl [3];
    bit fl [3];
    stl = '{stallE, stallM, stallW};
    fl  = '{flushE, flushM, flushW};
    for (int d = 0; d < 2; d++) begin
      for (int s = 2; s >= 0; s--) begin
        if (!resetn || (s == 2 && !has_w[d]) || fl[s]) st[d][s] = '0;
        else if (stl[s]) st[d][s] = st[d][s];
        else if (s > 0 && stl[s-1] && bos[d]) st[d][s] = '0;
        else st[d][s] = (s == 0) ? dec(instrD) : st[d][s-1];
      end
    end
  end

  task automatic chk(input string name, input int d, input logic [1:0] act, input logic [1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got %0d expected %0d", name, d, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        logic [5:0] op;
        logic       ri_exp;
        op = instrD[31:26];
`ifdef RI_DETECT_EN
        ri_exp = st[d][1].ri;
`else
        ri_exp = 1'b0;
`endif
        chk("sign_extD", d, 2'(sx[d]), 2'(!(op inside {[6'h0C:6'h0F]})));
        chk("reg_dstE", d, dstE[d], st[d][0].dst);
        chk("alu_imm_selE", d, 2'(immE[d]), 2'(st[d][0].imm));
        chk("reg_write_enE", d, 2'(rwE[d]), 2'(st[d][0].rw));
        chk("reg_write_enM", d, 2'(rwM[d]), 2'(st[d][1].rw));
        chk("mem_read_enM", d, 2'(mrM[d]), 2'(st[d][1].mr));
        chk("mem_write_enM", d, 2'(mwM[d]), 2'(st[d][1].mw));
        chk("mem_sizeM", d, szM[d], st[d][1].sz);
        chk("mem_signedM", d, 2'(sgM[d]), 2'(st[d][1].sg));
        chk("mem_to_regM", d, 2'(m2rM[d]), 2'(st[d][1].m2r));
        chk("hilo_writeM", d, 2'(hlM[d]), 2'(st[d][1].hl));
        chk("ri_excM", d, 2'(riM[d]), 2'(ri_exp));
        chk("reg_write_enW", d, 2'(rwW[d]), 2'(st[d][2].rw));
        chk("mem_to_regW", d, 2'(m2rW[d]), 2'(st[d][2].m2r));
      end
    end
  end

  // One cycle: wait for the edge, then present the next inputs {sE,sM,sW,fE,fM,fW}.
  task automatic cyc(input logic [31:0] ins, input logic [5:0] sf);
    @(posedge clk); #2;
    instrD = ins;
    {stallE, stallM, stallW, flushE, flushM, flushW} = sf;
  endtask

  logic [5:0] op_pool [28] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                               6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                               6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
                               6'h3F, 6'h1C, 6'h30, 6'h13};
  logic [5:0] fn_pool [26] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                               6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
                               6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2A, 6'h2B};
  logic [4:0] rt_pool [4] = '{5'h00, 5'h01, 5'h10, 5'h11};

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r = $urandom;
    r[31:26] = op_pool[$urandom_range(0, 27)];
    if (r[31:26] == 6'h00) r[5:0] = fn_pool[$urandom_range(0, 25)];
    if (r[31:26] == 6'h01) r[20:16] = rt_pool[$urandom_range(0, 3)];
    return r;
  endfunction

  initial begin
    logic ri_lit;
`ifdef RI_DETECT_EN
    ri_lit = 1'b1;
`else
    ri_lit = 1'b0;
`endif
    // Reset held with LW presented.
    instrD = LW;
    repeat (3) @(posedge clk);
    #2;
    chk("lit_rst_we_e", 0, 2'(rwE[0]), 2'd0);
    chk("lit_rst_mr_m", 0, 2'(mrM[0]), 2'd0);
    chk("lit_rst_dst_e", 0, dstE[0], 2'd0);
    resetn = 1'b1;
    cyc(FILL, 6'b0);
    chk("lit_lw_dst_e", 0, dstE[0], 2'b01);
    chk("lit_lw_imm_e", 0, 2'(immE[0]), 2'd1);
    cyc(FILL, 6'b0);
    chk("lit_lw_mr_m", 0, 2'(mrM[0]), 2'd1);
    chk("lit_lw_sz_m", 0, szM[0], 2'b10);
    chk("lit_lw_m2r_m", 0, 2'(m2rM[0]), 2'd1);

    // LB then LHU back to back.
    cyc(LB, 6'b0); cyc(LHU, 6'b0); cyc(FILL, 6'b0);
    chk("lit_lb_sz_m", 0, szM[0], 2'b00);
    chk("lit_lb_sg_m", 0, 2'(sgM[0]), 2'd1);
    cyc(FILL, 6'b0);
    chk("lit_lhu_sz_m", 0, szM[0], 2'b01);
    chk("lit_lhu_sg_m", 0, 2'(sgM[0]), 2'd0);
    chk("lit_lb_m2r_w", 0, 2'(m2rW[0]), 2'd1);
    chk("lit_nowb_m2r_w", 1, 2'(m2rW[1]), 2'd0);
    cyc(FILL, 6'b0);
    chk("lit_lhu_m2r_w", 0, 2'(m2rW[0]), 2'd1);

    // DIV then MFHI.
    cyc(DIV, 6'b0); cyc(MFHI, 6'b0); cyc(FILL, 6'b0);
    chk("lit_div_hl_m", 0, 2'(hlM[0]), 2'd1);
    chk("lit_div_rw_m", 0, 2'(rwM[0]), 2'd0);
    cyc(FILL, 6'b0);
    chk("lit_mfhi_rw_m", 0, 2'(rwM[0]), 2'd1);
    chk("lit_mfhi_hl_m", 0, 2'(hlM[0]), 2'd0);

    // REGIMM link vs non-link.
    cyc(BGEZAL, 6'b0); cyc(BGEZ, 6'b0);
    chk("lit_bgezal_dst_e", 0, dstE[0], 2'b10);
    chk("lit_bgezal_rw_e", 0, 2'(rwE[0]), 2'd1);
    cyc(FILL, 6'b0);
    chk("lit_bgez_rw_e", 0, 2'(rwE[0]), 2'd0);

    // SW held in E for two cycles.
    cyc(SW, 6'b0); cyc(FILL, 6'b100000);
    chk("lit_sw_imm_e", 0, 2'(immE[0]), 2'd1);
    cyc(FILL, 6'b100000);
    chk("lit_stall1_mw_bubble", 0, 2'(mwM[0]), 2'd0);
    chk("lit_stall1_mw_recap", 1, 2'(mwM[1]), 2'd1);
    cyc(FILL, 6'b0);
    chk("lit_stall2_mw_bubble", 0, 2'(mwM[0]), 2'd0);
    chk("lit_stall2_mw_recap", 1, 2'(mwM[1]), 2'd1);
    cyc(FILL, 6'b0);
    chk("lit_sw_mw_m", 0, 2'(mwM[0]), 2'd1);

    // Flush beats stall in E.
    cyc(ADDI, 6'b0); cyc(FILL, 6'b100100);
    chk("lit_addi_rw_e", 0, 2'(rwE[0]), 2'd1);
    cyc(FILL, 6'b0);
    chk("lit_flush_rw_e", 0, 2'(rwE[0]), 2'd0);
    chk("lit_flush_imm_e", 0, 2'(immE[0]), 2'd0);

    // Reserved opcode.
    cyc(INV, 6'b0); cyc(FILL, 6'b0); cyc(FILL, 6'b0);
    chk("lit_ri_m", 0, 2'(riM[0]), 2'(ri_lit));
    chk("lit_ri_rw_m", 0, 2'(rwM[0]), 2'd0);
    chk("lit_ri_mr_m", 0, 2'(mrM[0]), 2'd0);

    // flushE together with stallM.
    cyc(LW, 6'b0); cyc(SW, 6'b0); cyc(FILL, 6'b010100); cyc(FILL, 6'b0);
    chk("lit_fe_sm_imm_e", 0, 2'(immE[0]), 2'd0);
    chk("lit_fe_sm_mr_m", 0, 2'(mrM[0]), 2'd1);
    chk("lit_fe_sm_m2r_w", 0, 2'(m2rW[0]), 2'd0);

    // Randomised traffic with occasional async reset pulses.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 199) == 0) begin
        resetn = 1'b0;
        #1;
        chk("async_rst_rw_e", 0, 2'(rwE[0]), 2'd0);
        chk("async_rst_mr_m", 0, 2'(mrM[0]), 2'd0);
        chk("async_rst_rw_w", 0, 2'(rwW[0]), 2'd0);
        @(posedge clk); #2;
        resetn = 1'b1;
      end
      instrD = rnd_instr();
      stallE = ($urandom_range(0, 4) == 0);
      stallM = ($urandom_range(0, 4) == 0);
      stallW = ($urandom_range(0, 4) == 0);
      flushE = ($urandom_range(0, 11) == 0);
      flushM = ($urandom_range(0, 11) == 0);
      flushW = ($urandom_range(0, 11) == 0);
    end
    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_decoder.md
Name: ctrl_pipe_decoder

Overview:
- Parametrised main control decoder for the 5-stage MIPS pipeline.
- Decodes instrD in ID and carries control fields through the ID/EX, EX/MEM and (optionally) MEM/WB registers.
- Extends the basic decoder with byte/half/word load-store sizing, HI/LO write control, REGIMM link branches, per-stage flush, and bubble insertion on stall boundaries.

Parameters:
- WB_STAGE, 1, 1 = build MEM/WB control register and W outputs; 0 = W outputs tied to 0.
- BUBBLE_ON_STALL, 1, 1 = a stage whose upstream is stalled while it advances loads a bubble (all-zero control); 0 = it re-captures the upstream value.

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous active-low reset
- instrD  in  32  instruction in ID
- stallE, stallM, stallW  in  1 each  hold the corresponding pipeline register
- flushE, flushM, flushW  in  1 each  load a bubble into the corresponding register
- sign_extD  out  1  immediate sign-extend select (combinational)
- reg_dstE  out  2  00 rd, 01 rt, 10 $ra
- alu_imm_selE  out  1  ALU srcB = immediate
- reg_write_enE, reg_write_enM, reg_write_enW  out  1 each  GPR write enable per stage
- mem_read_enM, mem_write_enM  out  1 each  data memory enables
- mem_sizeM  out  2  00 byte, 01 half, 10 word
- mem_signedM  out  1  load sign-extends
- mem_to_regM, mem_to_regW  out  1 each  result = load data
- hilo_writeM  out  1  HI/LO write enable
- ri_excM  out  1  reserved-instruction flag (optional feature)

Behaviour:
- Decode (combinational; standard MIPS32 opcode/funct values from defines.vh):
  - sign_extD = 0 for ANDI, ORI, XORI, LUI; 1 otherwise.
  - R-type default: reg write, dst rd.
  - JR: no write.
  - JALR: write, dst rd.
  - MULT, MULTU, DIV, DIVU, MTHI, MTLO: no GPR write, hilo_write = 1.
  - MFHI, MFLO: write, dst rd.
  - ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI: write, dst rt, imm.
  - LB, LBU, LH, LHU, LW: write, dst rt, imm, mem_read, mem_to_reg; size per op; signed for LB and LH only.
  - SB, SH, SW: imm, mem_write, size per op.
  - BEQ, BNE, BGTZ, BLEZ, J, BLTZ, BGEZ: no write.
  - BLTZAL, BGEZAL (REGIMM rt field), JAL: write, dst 10.
  - Any other encoding decodes to an all-zero bubble.
- Register update rule, per stage X in {E, M, W}, on each rising clk:
  - flushX = 1: load bubble. Flush wins over stallX.
  - Else stallX = 1: hold.
  - Else upstream stalled (stallE/stallM for M/W respectively) and BUBBLE_ON_STALL = 1: load bubble.
  - Else capture upstream.
  - The ID source has no stall input; E always captures decode when not stalled or flushed.
- Latency: decode to E outputs 1 cycle; to M 2 cycles; to W 3 cycles.
- Reset: resetn low clears every register output to 0 immediately (async). Release is synchronous to clk; the first capture happens on the first edge with resetn high.
- Reset mid-stall or mid-flush: reset dominates; all stages become bubbles.
- Simultaneous flushE and stallM: E loads a bubble, M holds.
- WB_STAGE = 0: reg_write_enW and mem_to_regW are constant 0; stallW and flushW are ignored.

Optional Feature:
- RI_DETECT_EN defined:
  - An unrecognised opcode/funct sets ri_excD = 1, pipelined with the same stall/flush rules to ri_excM.
  - All other controls for that instruction remain a bubble.
- Undefined: ri_excM is constant 0 and no RI register is built.

Test Plan:
- Reset: hold resetn = 0 and apply LW; release -> all outputs 0 while reset is low; LW appears at E (reg_dstE = 01, alu_imm_selE = 1) 1 cycle after the first edge, then at M with mem_read_enM = 1, mem_sizeM = 10, mem_to_regM = 1.
- LB then LHU back-to-back -> M shows size 00 signed 1, then size 01 signed 0; mem_to_regW follows one cycle later.
- DIV then MFHI -> hilo_writeM = 1 with reg_write_enM = 0; next cycle reg_write_enM = 1 and hilo_writeM = 0.
- BGEZAL (opcode 000001, rt 10001) -> reg_dstE = 10, reg_write_enE = 1; BGEZ (rt 00001) -> reg_write_enE = 0.
- SW at E with stallE = 1, stallM = 0 for 2 cycles -> E holds SW, M receives bubbles (mem_write_enM = 0), SW reaches M once stallE drops; with BUBBLE_ON_STALL = 0, M shows mem_write_enM = 1 for the stalled cycles.
- ADDI at E with flushE = 1 and stallE = 1 -> E becomes a bubble; with RI_DETECT_EN, opcode 111111 -> ri_excM = 1 two cycles later with all enables 0.
